// File: rtl/subleq_mem_if.sv
// Memory transfer channel between the SUBLEQ controller (master) and the memory (slave).
// A transfer completes in any cycle where mem_req and mem_ack are both high.
interface subleq_mem_if #(
    parameter int WORD_SIZE = 16
);
    logic                 mem_req;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_ack;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/subleq_ctrl.sv
// SUBLEQ instruction sequencer: fetches A/B/C, reads mem[A] and mem[B], writes mem[B]-mem[A]
// back to B and branches to C when the result is <= 0; C = all-ones with a branch halts.
module subleq_ctrl #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 run,
    input  logic [WORD_SIZE-1:0] pc,
    output logic                 pc_inc,
    output logic                 pc_branch,
    output logic [WORD_SIZE-1:0] pc_target,
    output logic                 halted,
    subleq_mem_if.master         bus
);
    localparam logic [WORD_SIZE-1:0] ZERO_W   = {WORD_SIZE{1'b0}};
    localparam logic [WORD_SIZE-1:0] ONE_W    = {{(WORD_SIZE-1){1'b0}}, 1'b1};
    localparam logic [WORD_SIZE-1:0] ALL_ONES = {WORD_SIZE{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_B = 3'd2,
        FETCH_C = 3'd3,
        READ_A  = 3'd4,
        READ_B  = 3'd5,
        WRITE_B = 3'd6,
        HALT    = 3'd7
    } state_t;

    state_t               state_r, state_s;
    logic [WORD_SIZE-1:0] a_r, b_r, c_r, va_r, vb_r;
    logic [WORD_SIZE-1:0] mem_addr_r, addr_s;
    logic                 mem_req_r, mem_we_r, halted_r;
    logic [WORD_SIZE-1:0] diff_s;
    logic                 leq_s;
    logic                 ack_s;

    assign ack_s  = mem_req_r & bus.mem_ack;
    assign diff_s = vb_r - va_r;
    assign leq_s  = diff_s[WORD_SIZE-1] | (diff_s == ZERO_W);

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = diff_s;
    assign pc_target     = c_r;
    assign halted        = halted_r;

    // Next state, next transfer address and the combinational PC pulses.
    // The fetch address for the next word is pc+1 because the PC register steps at the same edge.
    always_comb begin
        state_s   = state_r;
        addr_s    = mem_addr_r;
        pc_inc    = 1'b0;
        pc_branch = 1'b0;
        case (state_r)
            IDLE: begin
                if (run) begin
                    state_s = FETCH_A;
                    addr_s  = pc;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH_A, FETCH_B: begin
                if (ack_s) begin
                    state_s = (state_r == FETCH_A) ? FETCH_B : FETCH_C;
                    addr_s  = pc + ONE_W;
                    pc_inc  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            FETCH_C: begin
                if (ack_s) begin
                    state_s = READ_A;
                    addr_s  = a_r;
                    pc_inc  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            READ_A, READ_B: begin
                if (ack_s) begin
                    state_s = (state_r == READ_A) ? READ_B : WRITE_B;
                    addr_s  = b_r;
                end else begin
                    state_s = state_r;
                end
            end
            WRITE_B: begin
                if (ack_s) begin
                    pc_branch = leq_s;
                    if (leq_s && (c_r == ALL_ONES)) begin
                        state_s = HALT;
                    end else if (run) begin
                        state_s = FETCH_A;
                        addr_s  = leq_s ? c_r : pc;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            HALT:    state_s = HALT;
            default: state_s = IDLE;
        endcase
    end

    // State, bus control registers and operand latches captured on each read ack.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_r    <= IDLE;
            a_r        <= ZERO_W;
            b_r        <= ZERO_W;
            c_r        <= ZERO_W;
            va_r       <= ZERO_W;
            vb_r       <= ZERO_W;
            mem_addr_r <= ZERO_W;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            mem_addr_r <= addr_s;
            mem_req_r  <= (state_s != IDLE) && (state_s != HALT);
            mem_we_r   <= (state_s == WRITE_B);
            halted_r   <= (state_s == HALT);
            if (ack_s) begin
                case (state_r)
                    FETCH_A: a_r  <= bus.mem_rdata;
                    FETCH_B: b_r  <= bus.mem_rdata;
                    FETCH_C: c_r  <= bus.mem_rdata;
                    READ_A:  va_r <= bus.mem_rdata;
                    READ_B:  vb_r <= bus.mem_rdata;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_subleq_ctrl.sv
// Self-checking bench for subleq_ctrl: an instruction-level SUBLEQ model predicts every bus
// transfer and PC pulse, and a memory responder with configurable wait states serves the DUT.
module tb_subleq_ctrl;
    localparam int W = 16;

    typedef struct {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] data;
        logic         inc;
        logic         br;
        logic [W-1:0] tgt;
    } xfer_t;

    logic         clk = 1'b0;
    logic         areset;
    logic         run;
    logic [W-1:0] pc;
    logic         pc_inc, pc_branch, halted;
    logic [W-1:0] pc_target;

    subleq_mem_if #(.WORD_SIZE(W)) bus ();

    subleq_ctrl #(.WORD_SIZE(W)) dut (
        .clk       (clk),
        .areset    (areset),
        .run       (run),
        .pc        (pc),
        .pc_inc    (pc_inc),
        .pc_branch (pc_branch),
        .pc_target (pc_target),
        .halted    (halted),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem     [0:65535];
    logic [W-1:0] ref_mem [0:65535];
    logic [W-1:0] ref_pc;
    bit           ref_halt;
    xfer_t        exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           inc_cnt, br_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Instruction-level reference: one SUBLEQ step per iteration, recording the expected bus traffic.
    task automatic model_exec(input int n);
        logic [W-1:0] a, b, c, va, vb, d;
        bit           leq;
        for (int k = 0; k < n && !ref_halt; k++) begin
            a  = ref_mem[ref_pc];
            b  = ref_mem[W'(ref_pc + 16'd1)];
            c  = ref_mem[W'(ref_pc + 16'd2)];
            va = ref_mem[a];
            vb = ref_mem[b];
            d  = vb - va;
            leq = ($signed(d) <= 0);
            exp_q.push_back('{1'b0, ref_pc, 16'd0, 1'b1, 1'b0, 16'd0});
            exp_q.push_back('{1'b0, W'(ref_pc + 16'd1), 16'd0, 1'b1, 1'b0, 16'd0});
            exp_q.push_back('{1'b0, W'(ref_pc + 16'd2), 16'd0, 1'b1, 1'b0, 16'd0});
            exp_q.push_back('{1'b0, a, 16'd0, 1'b0, 1'b0, 16'd0});
            exp_q.push_back('{1'b0, b, 16'd0, 1'b0, 1'b0, 16'd0});
            exp_q.push_back('{1'b1, b, d, 1'b0, leq, c});
            ref_mem[b] = d;
            ref_pc = leq ? c : W'(ref_pc + 16'd3);
            if (leq && c == 16'hFFFF) ref_halt = 1'b1;
        end
    endtask

    task automatic sync_model();
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
        ref_pc   = pc;
        ref_halt = 1'b0;
        exp_q.delete();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        run = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 16'd0;
        pc = 16'd0;
        @(posedge clk); #1;
        areset = 1'b0;
    endtask

    // Memory responder and per-cycle checker; returns once the expected traffic has drained.
    task automatic drive_bus(input int dmin, input int dmax, input bit abort_on_write);
        int           budget = 5000;
        int           wait_cnt = 0;
        int           dly = 0;
        bit           busy = 0;
        bit           ack;
        bit           inc_p, br_p;
        logic [W-1:0] tgt_p, h_addr, h_wd;
        logic         h_we;
        xfer_t        e;
        inc_cnt = 0;
        br_cnt  = 0;
        while (budget > 0) begin
            run = (exp_q.size() > 1);
            ack = 1'b0;
            if (bus.mem_req) begin
                if (!busy) begin
                    busy = 1; wait_cnt = 0; dly = $urandom_range(dmax, dmin);
                    h_addr = bus.mem_addr; h_we = bus.mem_we; h_wd = bus.mem_wdata;
                end else begin
                    check_eq("addr_stable", bus.mem_addr, h_addr);
                    check_eq("we_stable", bus.mem_we, h_we);
                    check_eq("wdata_stable", bus.mem_wdata, h_wd);
                end
                if (abort_on_write && bus.mem_we) begin
                    bus.mem_ack = 1'b0;
                    areset = 1'b1;
                    @(posedge clk); #1;
                    check_eq("abort_req", bus.mem_req, 0);
                    check_eq("abort_we", bus.mem_we, 0);
                    check_eq("abort_branch", pc_branch, 0);
                    check_eq("abort_inc", pc_inc, 0);
                    check_eq("abort_halted", halted, 0);
                    areset = 1'b0;
                    exp_q.delete();
                    return;
                end
                ack = (wait_cnt >= dly);
            end
            bus.mem_ack   = ack;
            bus.mem_rdata = (ack && bus.mem_req) ? mem[bus.mem_addr] : W'($urandom);
            #1;
            if (ack) begin
                busy = 0;
                check_eq("xfer_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("xfer_we", bus.mem_we, e.we);
                    check_eq("xfer_addr", bus.mem_addr, e.addr);
                    if (e.we) check_eq("xfer_wdata", bus.mem_wdata, e.data);
                    check_eq("pc_inc", pc_inc, e.inc);
                    check_eq("pc_branch", pc_branch, e.br);
                    if (e.br) check_eq("pc_target", pc_target, e.tgt);
                    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                end
            end else begin
                check_eq("idle_pulses", {pc_inc, pc_branch}, 0);
            end
            inc_p = pc_inc; br_p = pc_branch; tgt_p = pc_target;
            if (inc_p) inc_cnt++;
            if (br_p) br_cnt++;
            @(posedge clk); #1;
            if (br_p) pc = tgt_p;
            else if (inc_p) pc = W'(pc + 16'd1);
            wait_cnt++;
            budget--;
            if (exp_q.size() == 0 && !bus.mem_req) break;
        end
        check_eq("drain_in_budget", budget > 0, 1);
    endtask

    task automatic run_instr(input int n, input int dmin, input int dmax);
        int diffs = 0;
        sync_model();
        model_exec(n);
        drive_bus(dmin, dmax, 1'b0);
        check_eq("final_pc", pc, ref_pc);
        check_eq("final_halted", halted, ref_halt);
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check_eq("final_mem", diffs, 0);
    endtask

    task automatic load_straight();
        clear_mem();
        mem[0] = 16'd3; mem[1] = 16'd4; mem[2] = 16'd6; mem[3] = 16'd5; mem[4] = 16'd7;
    endtask

    initial begin
        areset = 1'b1; run = 1'b0; pc = 16'd0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 16'd0;
        do_reset();
        check_eq("rst_req", bus.mem_req, 0);
        check_eq("rst_we", bus.mem_we, 0);
        check_eq("rst_addr", bus.mem_addr, 0);
        check_eq("rst_wdata", bus.mem_wdata, 0);
        check_eq("rst_target", pc_target, 0);
        check_eq("rst_pulses", {pc_inc, pc_branch}, 0);
        check_eq("rst_halted", halted, 0);

        // Straight-line instruction, no wait states.
        load_straight();
        run_instr(1, 0, 0);
        check_eq("straight_mem4", mem[4], 16'd2);
        check_eq("straight_pc", pc, 16'd3);
        check_eq("straight_incs", inc_cnt, 3);
        check_eq("straight_brs", br_cnt, 0);
        run_instr(1, 0, 0);

        // Branch on a zero result, then continue at the target.
        do_reset();
        load_straight();
        mem[3] = 16'd7;
        run_instr(1, 0, 0);
        check_eq("zero_mem4", mem[4], 16'd0);
        check_eq("zero_pc", pc, 16'd6);
        check_eq("zero_brs", br_cnt, 1);
        run_instr(1, 0, 0);

        // Overflowing difference is judged on its truncated value only.
        do_reset();
        clear_mem();
        mem[0] = 16'd10; mem[1] = 16'd11; mem[2] = 16'd3;
        mem[3] = 16'd12; mem[4] = 16'd13; mem[5] = 16'd0;
        mem[10] = 16'h0001; mem[11] = 16'h8000; mem[12] = 16'h0001; mem[13] = 16'h0001;
        run_instr(2, 0, 0);
        check_eq("ovf_mem11", mem[11], 16'h7FFF);
        check_eq("ovf_mem13", mem[13], 16'h0000);
        check_eq("ovf_brs", br_cnt, 1);
        check_eq("ovf_pc", pc, 16'd0);

        // Three wait states on every transfer.
        do_reset();
        load_straight();
        run_instr(1, 3, 3);
        check_eq("wait_mem4", mem[4], 16'd2);
        check_eq("wait_pc", pc, 16'd3);
        check_eq("wait_incs", inc_cnt, 3);

        // Reset while the write is stalled, then restart from the current PC.
        do_reset();
        load_straight();
        sync_model();
        model_exec(1);
        drive_bus(2, 2, 1'b1);
        check_eq("abort_mem4", mem[4], 16'd7);
        check_eq("abort_pc", pc, 16'd3);
        run_instr(1, 0, 1);

        // Randomised programs with random wait states.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 65536; i++) mem[i] = W'($urandom);
            pc = W'($urandom);
            run_instr(25, 0, 2);
        end

        // Halt: branch to all-ones ends execution for good.
        do_reset();
        clear_mem();
        mem[0] = 16'd3; mem[1] = 16'd3; mem[2] = 16'hFFFF; mem[3] = 16'd5;
        run_instr(1, 0, 1);
        check_eq("halt_pc", pc, 16'hFFFF);
        check_eq("halt_brs", br_cnt, 1);
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.mem_ack = i[0];
            #1;
            check_eq("halt_req", bus.mem_req, 0);
            check_eq("halt_pulses", {pc_inc, pc_branch}, 0);
            check_eq("halt_flag", halted, 1);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
